sram_uart_dump: RTL
===================

Name: sram_uart_dump

Overview:
Reads a contiguous region of the 16-bit external SRAM and serialises it over the UART TX line as 8N1 bytes, high byte first. It is the reverse path of the UART-to-SRAM loader and sits beside it under the top-level FSM. It lets decoded RGB/YUV buffers be dumped to a host in the same byte order as the .sram_d1/.sram_d2 input files. It shares the SRAM controller port with the other units, and the top FSM grants it access only while it is active.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); minimum 2
SRAM_READ_LATENCY, 2, cycles from SRAM_address driven to SRAM_read_data valid
ADDR_W, 18, SRAM word-address width

Ports:
Clock  input  1  50 MHz system clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  single-cycle pulse; starts a dump when idle
Base_address  input  ADDR_W  first SRAM word address, sampled on Start
Word_count  input  ADDR_W  number of 16-bit words to send, sampled on Start
SRAM_address  output  ADDR_W  SRAM word address
SRAM_we_n  output  1  always 1 (read-only unit)
SRAM_read_data  input  16  SRAM read data
UART_TX  output  1  serial line; idles high
Busy  output  1  high from the cycle after an accepted Start until Done
Done  output  1  single-cycle pulse when the last stop bit completes
Bytes_sent  output  ADDR_W+1  count of bytes fully transmitted in the current dump

Behaviour:
- Reset values: UART_TX=1, SRAM_we_n=1, SRAM_address=0, Busy=0, Done=0, Bytes_sent=0, FSM in S_DUMP_IDLE, tx shifter idle.
- States:
  - S_DUMP_IDLE
    - On Start: latch Base_address into addr_reg and Word_count into remaining.
    - Clear Bytes_sent.
    - If Word_count==0, go to S_DUMP_DONE; otherwise go to S_DUMP_READ.
    - Start is ignored in every state other than S_DUMP_IDLE.
  - S_DUMP_READ: drive SRAM_address=addr_reg for one cycle, then go to S_DUMP_WAIT.
  - S_DUMP_WAIT
    - Count SRAM_READ_LATENCY cycles, then capture SRAM_read_data into word_reg.
    - Go to S_DUMP_TX_HI.
  - S_DUMP_TX_HI
    - Load word_reg[15:8] into the tx sub-module when tx_ready=1.
    - Wait for tx_done, increment Bytes_sent, go to S_DUMP_TX_LO.
  - S_DUMP_TX_LO
    - Same as S_DUMP_TX_HI, but with word_reg[7:0].
    - On tx_done: addr_reg+=1 (wraps modulo 2^ADDR_W) and remaining-=1.
    - If remaining reaches 0, go to S_DUMP_DONE; otherwise go to S_DUMP_READ.
  - S_DUMP_DONE: pulse Done for one cycle, deassert Busy, return to S_DUMP_IDLE.
- UART frame:
  - One start bit (0), then 8 data bits LSB first, then one stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
  - No idle gap is inserted between bytes beyond the SRAM fetch: the next SRAM read is issued only after the low-byte stop bit completes.
- Throughput: one word every 20*CLKS_PER_BIT + 1 + SRAM_READ_LATENCY + 2 cycles (FSM handoff).
- SRAM_address holds its last value outside S_DUMP_READ/S_DUMP_WAIT; the top level muxes it.
- Reset mid-dump:
  - UART_TX returns to 1 immediately; a partial frame is truncated.
  - All counters clear; no Done pulse is generated.
- Start and Done never coincide, because Start is not accepted in S_DUMP_DONE.
- Bytes_sent equals 2*Word_count at Done.

Decomposition:
- Shared package dump_pkg:
  - dump_state_type enum (S_DUMP_IDLE, S_DUMP_READ, S_DUMP_WAIT, S_DUMP_TX_HI, S_DUMP_TX_LO, S_DUMP_DONE).
  - tx_state_type enum (S_TX_IDLE, S_TX_START, S_TX_DATA, S_TX_STOP).
  - UART_CLKS_PER_BIT_115200 = 434 constant.
- One sub-module, uart_tx_byte:
  - Inputs: Clock, Reset, Load, Data[7:0].
  - Outputs: TX, Ready, Done_pulse.
  - Internals: bit-period counter and 3-bit data index.
  - Ready is low from Load until the stop bit ends.
  - Load while not Ready is ignored.

Test Plan:
- CLKS_PER_BIT=4; SRAM[0x100]=16'hA55A; Start with Base=0x100, Count=1 → UART_TX decodes bytes A5 then 5A. Done pulses once, 80+fetch cycles after Start. Bytes_sent=2.
- Count=0, Base=0x200 → Done pulses 2 cycles after Start, UART_TX stays 1 throughout, no SRAM read address is issued, Bytes_sent=0.
- Base=0x3FFFF, Count=2, SRAM[0x3FFFF]=0x1122, SRAM[0x0]=0x3344 → bytes 11 22 33 44; the address wraps to 0.
- Start pulsed again during the third frame of a 4-word dump → ignored; exactly 8 bytes are sent and a single Done pulse occurs.
- Reset asserted mid data-bit of byte 2 → UART_TX=1 and Busy=0 in the same cycle; Bytes_sent=0, no Done pulse. A subsequent Start dumps normally.
- Bench loads the 57600-word motorcycle.sram_d1 image; dump with Base=0, Count=57600 is captured by a UART receiver model and written to a file → byte-identical to the input file.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and constants for the SRAM-to-UART dump path.
package dump_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 434;

  typedef enum logic [2:0] {
    S_DUMP_IDLE,
    S_DUMP_READ,
    S_DUMP_WAIT,
    S_DUMP_TX_HI,
    S_DUMP_TX_LO,
    S_DUMP_DONE
  } dump_state_type;

  typedef enum logic [1:0] {
    S_TX_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP
  } tx_state_type;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; TX is registered so it idles high straight out of reset.
//   state      | meaning
//   S_TX_IDLE  | line high, Ready=1, waiting for Load
//   S_TX_START | start bit (0)
//   S_TX_DATA  | data bits, LSB first
//   S_TX_STOP  | stop bit (1); Done_pulse in its last cycle
module uart_tx_byte
  import dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       TX,
  output logic       Ready,
  output logic       Done_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_type  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the bit that starts on the next edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    tx_d       = tx_q;
    Done_pulse = 1'b0;
    case (state_q)
      S_TX_IDLE: begin
        if (Load) begin
          state_d = S_TX_START;
          cnt_d   = BIT_LAST;
          data_d  = Data;
          tx_d    = 1'b0;
        end
      end
      S_TX_START: begin
        if (cnt_q == '0) begin
          state_d = S_TX_DATA;
          cnt_d   = BIT_LAST;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TX_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (idx_q == 3'd7) begin
            state_d = S_TX_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TX_STOP: begin
        if (cnt_q == '0) begin
          state_d    = S_TX_IDLE;
          Done_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_TX_IDLE;
    endcase
  end

  assign TX    = tx_q;
  assign Ready = (state_q == S_TX_IDLE);

endmodule

// File: rtl/sram_uart_dump.sv
// Streams a block of 16-bit SRAM words out of the UART, high byte first.
//   state        | meaning
//   S_DUMP_IDLE  | waiting for Start
//   S_DUMP_READ  | SRAM_address presents the current word
//   S_DUMP_WAIT  | SRAM read latency, capture word at the end
//   S_DUMP_TX_HI | sending word[15:8]
//   S_DUMP_TX_LO | sending word[7:0], then advance address
//   S_DUMP_DONE  | one-cycle wrap-up, Done follows
module sram_uart_dump
  import dump_pkg::*;
#(
  parameter int CLKS_PER_BIT      = UART_CLKS_PER_BIT_115200,
  parameter int SRAM_READ_LATENCY = 2,
  parameter int ADDR_W            = 18
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Word_count,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic              SRAM_we_n,
  input  logic [15:0]       SRAM_read_data,
  output logic              UART_TX,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Bytes_sent
);

  localparam int LW = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [LW-1:0] WAIT_LAST = LW'(SRAM_READ_LATENCY - 1);

  dump_state_type    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       word_q, word_d;
  logic [LW-1:0]     wait_q, wait_d;
  logic [ADDR_W:0]   bytes_q, bytes_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       tx_load, tx_ready, tx_done;
  logic [7:0] tx_data;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load       (tx_load),
    .Data       (tx_data),
    .TX         (UART_TX),
    .Ready      (tx_ready),
    .Done_pulse (tx_done)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_DUMP_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      sram_addr_q <= '0;
      word_q      <= '0;
      wait_q      <= '0;
      bytes_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      sram_addr_q <= sram_addr_d;
      word_q      <= word_d;
      wait_q      <= wait_d;
      bytes_q     <= bytes_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    sram_addr_d = sram_addr_q;
    word_d      = word_q;
    wait_d      = wait_q;
    bytes_d     = bytes_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_load     = 1'b0;
    tx_data     = word_q[15:8];
    case (state_q)
      S_DUMP_IDLE: begin
        if (Start) begin
          addr_d  = Base_address;
          rem_d   = Word_count;
          bytes_d = '0;
          busy_d  = 1'b1;
          if (Word_count == '0) begin
            state_d = S_DUMP_DONE;
          end else begin
            state_d     = S_DUMP_READ;
            sram_addr_d = Base_address;
          end
        end
      end
      S_DUMP_READ: begin
        state_d = S_DUMP_WAIT;
        wait_d  = WAIT_LAST;
      end
      S_DUMP_WAIT: begin
        if (wait_q == '0) begin
          word_d  = SRAM_read_data;
          state_d = S_DUMP_TX_HI;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end
      S_DUMP_TX_HI: begin
        tx_load = tx_ready;
        if (tx_done) begin
          bytes_d = bytes_q + (ADDR_W + 1)'(1);
          state_d = S_DUMP_TX_LO;
        end
      end
      S_DUMP_TX_LO: begin
        tx_data = word_q[7:0];
        tx_load = tx_ready;
        if (tx_done) begin
          bytes_d = bytes_q + (ADDR_W + 1)'(1);
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = S_DUMP_DONE;
          end else begin
            state_d     = S_DUMP_READ;
            sram_addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DUMP_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DUMP_IDLE;
      end
      default: state_d = S_DUMP_IDLE;
    endcase
  end

  assign SRAM_address = sram_addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Bytes_sent   = bytes_q;

endmodule
